gio_mem_writer: RTL and testbench

- Input-side counterpart of the CPU's data-memory port-B read path. Port B is otherwise used only to read memory out to the board.
- This block synchronizes and debounces the 8 GIO pins (Pong paddle buttons/switches). On each accepted change it writes the pin state and a change counter into data memory through port B.
- Result: game firmware polls fixed RAM words instead of raw pins.

---
 rtl/gio_mem_writer_if.sv | 34 +++
 rtl/gio_mem_writer.sv | 125 ++++++++++++
 tb/tb_gio_mem_writer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gio_mem_writer_if.sv
// Port-B memory write bus plus GIO pin inputs and status for gio_mem_writer.
// slave = the writer block, master = whoever drives pins/enable and consumes the writes.
interface gio_mem_writer_if;
    logic        enable;
    logic [7:0]  GIO_pins;
    logic [15:0] addr_b;
    logic [15:0] data_b;
    logic        we_b;
    logic [7:0]  pins_db;
    logic [15:0] change_count;
    logic        busy;

    modport slave (
        input  enable,
        input  GIO_pins,
        output addr_b,
        output data_b,
        output we_b,
        output pins_db,
        output change_count,
        output busy
    );

    modport master (
        output enable,
        output GIO_pins,
        input  addr_b,
        input  data_b,
        input  we_b,
        input  pins_db,
        input  change_count,
        input  busy
    );
endinterface

// File: rtl/gio_mem_writer.sv
// Syncs/debounces 8 GIO pins; each accepted change writes pin state then change count to port B.
// Latency: DEBOUNCE_CYCLES+3 edges from first sample to WR_S; no backpressure, one sequence in flight.
module gio_mem_writer #(
    parameter logic [15:0] BASE_ADDR       = 16'h00F0,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    gio_mem_writer_if.slave  bus
);
    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [15:0]      CNT_ADDR = BASE_ADDR + 16'd1;

    typedef enum logic [2:0] {
        INIT_S,
        INIT_C,
        IDLE,
        WR_S,
        WR_C
    } state_t;

    logic [7:0]       r_s1;
    logic [7:0]       r_s2;
    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic [7:0]       r_pins_db;
    logic [15:0]      r_change_count;
    logic             r_we;
    logic [15:0]      r_addr;
    logic [15:0]      r_data;
    logic             r_busy;

    logic             w_stable;
    logic             w_commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 8'h00;
            r_s2 <= 8'h00;
        end else begin
            r_s1 <= bus.GIO_pins;
            r_s2 <= r_s1;
        end
    end

    // Counter saturates at the limit so a long-held value stays "stable" indefinitely.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand <= 8'h00;
            r_cnt  <= '0;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
        end else if (r_cnt < DB_LIMIT) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign w_stable = (r_cnt == DB_LIMIT);
    assign w_commit = bus.enable && w_stable && (r_cand != r_pins_db);

    // Output registers are loaded with the decode of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= INIT_S;
            r_pins_db      <= 8'h00;
            r_change_count <= 16'h0000;
            r_we           <= 1'b1;
            r_addr         <= BASE_ADDR;
            r_data         <= 16'h0000;
            r_busy         <= 1'b1;
        end else begin
            case (r_state)
                INIT_S: begin
                    r_state <= INIT_C;
                    r_we    <= 1'b1;
                    r_addr  <= CNT_ADDR;
                    r_data  <= 16'h0000;
                    r_busy  <= 1'b1;
                end
                INIT_C, WR_C: begin
                    r_state <= IDLE;
                    r_we    <= 1'b0;
                    r_addr  <= BASE_ADDR;
                    r_data  <= 16'h0000;
                    r_busy  <= 1'b0;
                end
                IDLE: begin
                    if (w_commit) begin
                        r_state        <= WR_S;
                        r_pins_db      <= r_cand;
                        r_change_count <= r_change_count + 16'd1;
                        r_we           <= 1'b1;
                        r_addr         <= BASE_ADDR;
                        r_data         <= {8'h00, r_cand};
                        r_busy         <= 1'b1;
                    end
                end
                WR_S: begin
                    r_state <= WR_C;
                    r_we    <= 1'b1;
                    r_addr  <= CNT_ADDR;
                    r_data  <= r_change_count;
                    r_busy  <= 1'b1;
                end
                default: begin
                    r_state <= INIT_S;
                    r_we    <= 1'b1;
                    r_addr  <= BASE_ADDR;
                    r_data  <= 16'h0000;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.addr_b       = r_addr;
    assign bus.data_b       = r_data;
    assign bus.we_b         = r_we;
    assign bus.pins_db      = r_pins_db;
    assign bus.change_count = r_change_count;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_gio_mem_writer.sv
// Directed bench for gio_mem_writer: expected port-B writes are queued as stimulus is applied
// and popped by a monitor on every observed write cycle.
module tb_gio_mem_writer;
    localparam logic [15:0] BASE = 16'h00F0;
    localparam int          DB   = 4;

    logic clk;
    logic reset;
    gio_mem_writer_if bif ();

    gio_mem_writer #(
        .BASE_ADDR       (BASE),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic [15:0] exp_cnt;
    logic [7:0]  exp_db;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every write cycle must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && bif.we_b === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {bif.addr_b, bif.data_b}, 32'h0);
            end else begin
                check("write", {bif.addr_b, bif.data_b}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_change(input logic [7:0] v);
        exp_cnt = exp_cnt + 16'd1;
        exp_db  = v;
        exp_q.push_back({BASE, 8'h00, v});
        exp_q.push_back({BASE + 16'd1, exp_cnt});
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (exp_q.size() == 0 && bif.busy == 1'b0) done = 1'b1;
        end
        check(tag, {31'h0, done}, 32'h1);
    endtask

    task automatic wait_we(input string tag, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            n++;
            if (bif.we_b) seen = 1'b1;
        end
        check(tag, {31'h0, seen}, 32'h1);
    endtask

    task automatic wait_addr(input string tag, input logic [15:0] a);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (bif.we_b && bif.addr_b == a) seen = 1'b1;
        end
        check(tag, {31'h0, seen}, 32'h1);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pins_db"}, {24'h0, bif.pins_db}, {24'h0, exp_db});
        check({tag, "_count"}, {16'h0, bif.change_count}, {16'h0, exp_cnt});
    endtask

    int n;

    initial begin
        reset        = 1'b1;
        bif.enable   = 1'b1;
        bif.GIO_pins = 8'h00;
        exp_cnt      = 16'h0000;
        exp_db       = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {31'h0, bif.busy}, 32'h1);
        check("reset_we", {31'h0, bif.we_b}, 32'h1);
        exp_q.push_back({BASE, 16'h0000});
        exp_q.push_back({BASE + 16'd1, 16'h0000});
        mon_en = 1'b1;
        drain("init_drain");
        check_state("after_init");
        repeat (10) tick();
        check("idle_busy", {31'h0, bif.busy}, 32'h0);

        // First change and its latency from the first sampling edge.
        bif.GIO_pins = 8'h05;
        push_change(8'h05);
        wait_we("lat_seen", n);
        check("latency", n - 1, DB + 3);
        drain("c05_drain");
        check_state("after_05");

        // Short glitch must not commit.
        bif.GIO_pins = 8'h80;
        repeat (3) tick();
        bif.GIO_pins = 8'h05;
        repeat (20) tick();
        check_state("after_glitch");

        // New change arrives while the previous sequence is in WR_C.
        bif.GIO_pins = 8'h01;
        push_change(8'h01);
        wait_addr("wr_c_seen", BASE + 16'd1);
        bif.GIO_pins = 8'h02;
        push_change(8'h02);
        drain("overlap_drain");
        repeat (10) tick();
        check_state("after_overlap");

        // Pending change held off by enable, committed on the next IDLE cycle.
        bif.enable   = 1'b0;
        bif.GIO_pins = 8'h33;
        repeat (20) tick();
        check("en_off_busy", {31'h0, bif.busy}, 32'h0);
        check_state("en_off");
        bif.enable = 1'b1;
        push_change(8'h33);
        wait_we("en_seen", n);
        check("en_latency", n, 1);
        drain("en_drain");

        // Counter wrap.
        force dut.r_change_count = 16'hFFFF;
        tick();
        release dut.r_change_count;
        exp_cnt = 16'hFFFF;
        tick();
        bif.GIO_pins = 8'h44;
        push_change(8'h44);
        drain("wrap_drain");
        check_state("after_wrap");

        // Reset during WR_S aborts the sequence and re-zeroes memory.
        bif.GIO_pins = 8'h3C;
        exp_q.push_back({BASE, 16'h003C});
        wait_addr("wr_s_seen", BASE);
        reset = 1'b1;
        exp_q.push_back({BASE, 16'h0000});
        exp_q.push_back({BASE + 16'd1, 16'h0000});
        tick();
        reset = 1'b0;
        check("rst_mid_busy", {31'h0, bif.busy}, 32'h1);
        check("rst_mid_addr", {16'h0, bif.addr_b}, {16'h0, BASE});
        exp_cnt = 16'h0000;
        exp_db  = 8'h00;
        check_state("after_mid_reset");
        push_change(8'h3C);
        drain("post_reset_drain");
        repeat (10) tick();
        check_state("final");
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
